// File: rtl/mmio_pkg.sv
// rtl/mmio_pkg.sv - mmio_bridge shared constants: window base, register offsets, LFSR seed/taps
package mmio_pkg;

    localparam logic [7:0] WIN_BASE = 8'hFF;

    localparam logic [3:0] OFF_MOLE_LED  = 4'h0;
    localparam logic [3:0] OFF_BTN_LEVEL = 4'h1;
    localparam logic [3:0] OFF_BTN_EVENT = 4'h2;
    localparam logic [3:0] OFF_TIMER     = 4'h3;
    localparam logic [3:0] OFF_SCORE     = 4'h4;
    localparam logic [3:0] OFF_RNG       = 4'h5;

    localparam int SCORE_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Taps 16,14,13,11 expressed as bit positions of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - one-bit 2-flop synchronizer plus counter debouncer with rise pulse
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic rise
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             differ;
    logic             accept;

    assign differ = (sync[1] != level);
    assign accept = differ && (cnt == CNT_LAST);
    // Combinational so the event register sets on the same edge the level changes
    assign rise   = accept && sync[1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], raw};
            if (!differ) begin
                cnt <= '0;
            end else if (accept) begin
                level <= sync[1];
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// rtl/mmio_bridge.sv - dmem address decoder with Whack-A-Mole peripheral registers (option: MMIO_RNG_EN)
module mmio_bridge
    import mmio_pkg::*;
#(
    parameter int NUM_BTN         = 9,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int TICK_DIV        = 50000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [11:0]         address_dmem,
    input  logic [31:0]         d_dmem,
    input  logic                wren,
    output logic [31:0]         q_dmem,
    output logic                ram_wren,
    input  logic [31:0]         ram_q,
    input  logic [NUM_BTN-1:0]  btn_raw,
    output logic [NUM_BTN-1:0]  mole_led,
    output logic [SCORE_W-1:0]  score
);
    localparam int PRE_W = $clog2(TICK_DIV + 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic               in_win;
    logic               reg_we;
    logic [3:0]         offset;
    logic [NUM_BTN-1:0] levels;
    logic [NUM_BTN-1:0] rises;
    logic [NUM_BTN-1:0] events;
    logic [NUM_BTN-1:0] clear_mask;
    logic [31:0]        timer;
    logic [PRE_W-1:0]   prescale;
    logic [31:0]        reg_rd;

    assign in_win   = (address_dmem[11:4] == WIN_BASE);
    assign offset   = address_dmem[3:0];
    assign reg_we   = wren && in_win;
    assign ram_wren = in_win ? 1'b0 : wren;
    assign q_dmem   = in_win ? reg_rd : ram_q;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clock (clock),
                .reset (reset),
                .raw   (btn_raw[gi]),
                .level (levels[gi]),
                .rise  (rises[gi])
            );
        end
    endgenerate

    assign clear_mask = (reg_we && offset == OFF_BTN_EVENT) ? d_dmem[NUM_BTN-1:0] : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            mole_led <= '0;
            score    <= '0;
            events   <= '0;
            timer    <= '0;
            prescale <= '0;
        end else begin
            // A new press beats a simultaneous write-1-to-clear of the same bit
            events <= (events & ~clear_mask) | rises;

            if (prescale == PRE_LAST) begin
                prescale <= '0;
                timer    <= timer + 32'd1;
            end else begin
                prescale <= prescale + 1'b1;
            end

            if (reg_we) begin
                case (offset)
                    OFF_MOLE_LED: mole_led <= d_dmem[NUM_BTN-1:0];
                    OFF_SCORE:    score    <= d_dmem[SCORE_W-1:0];
                    OFF_TIMER: begin
                        timer    <= d_dmem;
                        prescale <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MMIO_RNG_EN
    logic [15:0] lfsr;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lfsr <= LFSR_SEED;
        else       lfsr <= lfsr_next(lfsr);
    end
`endif

    always_comb begin
        reg_rd = 32'd0;
        case (offset)
            OFF_MOLE_LED:  reg_rd = 32'(mole_led);
            OFF_BTN_LEVEL: reg_rd = 32'(levels);
            OFF_BTN_EVENT: reg_rd = 32'(events);
            OFF_TIMER:     reg_rd = timer;
            OFF_SCORE:     reg_rd = 32'(score);
`ifdef MMIO_RNG_EN
            OFF_RNG:       reg_rd = {16'b0, lfsr};
`endif
            default:       reg_rd = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// tb/tb_mmio_bridge.sv - self-checking bench for mmio_bridge (honours MMIO_RNG_EN)
module tb_mmio_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] address_dmem;
    logic [31:0] d_dmem;
    logic        wren;
    logic [31:0] q_dmem;
    logic        ram_wren;
    logic [31:0] ram_q;
    logic [8:0]  btn_raw;
    logic [8:0]  mole_led;
    logic [15:0] score;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mmio_bridge #(.NUM_BTN(9), .DEBOUNCE_CYCLES(4), .TICK_DIV(3)) dut (
        .clock        (clock),
        .reset        (reset),
        .address_dmem (address_dmem),
        .d_dmem       (d_dmem),
        .wren         (wren),
        .q_dmem       (q_dmem),
        .ram_wren     (ram_wren),
        .ram_q        (ram_q),
        .btn_raw      (btn_raw),
        .mole_led     (mole_led),
        .score        (score)
    );

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        logic        wr;
        logic [31:0] rq;
        logic [31:0] exp_q;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [11:0] a, input logic [31:0] d, input logic w, input logic [31:0] rq);
        address_dmem = a;
        d_dmem       = d;
        wren         = w;
        ram_q        = rq;
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        drive(a, d, 1'b1, 32'd0);
        step(1);
        wren = 1'b0;
    endtask

    task automatic rd(input logic [11:0] a, output logic [31:0] v);
        drive(a, 32'd0, 1'b0, 32'd0);
        v = q_dmem;
    endtask

    logic [31:0] v;
    int zeros;

    initial begin
        vecs[0]  = '{12'h010, 32'h0000_1234, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b1};
        vecs[1]  = '{12'h010, 32'h0000_0000, 1'b0, 32'h0000_1234, 32'h0000_1234, 1'b0};
        vecs[2]  = '{12'hFF0, 32'h0000_01FF, 1'b1, 32'hAAAA_5555, 32'h0000_0000, 1'b0};
        vecs[3]  = '{12'hFF4, 32'h0000_0042, 1'b1, 32'hAAAA_5555, 32'h0000_0000, 1'b0};
        vecs[4]  = '{12'hFF0, 32'h0000_0000, 1'b0, 32'hAAAA_5555, 32'h0000_01FF, 1'b0};
        vecs[5]  = '{12'hFF4, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF, 32'h0000_0042, 1'b0};
        vecs[6]  = '{12'hFEF, 32'h0000_0007, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
        vecs[7]  = '{12'hFF6, 32'hFFFF_FFFF, 1'b1, 32'h1111_1111, 32'h0000_0000, 1'b0};
        vecs[8]  = '{12'hFF6, 32'h0000_0000, 1'b0, 32'h1111_1111, 32'h0000_0000, 1'b0};
        vecs[9]  = '{12'hFF1, 32'h0000_01FF, 1'b1, 32'h2222_2222, 32'h0000_0000, 1'b0};
        vecs[10] = '{12'hFF1, 32'h0000_0000, 1'b0, 32'h2222_2222, 32'h0000_0000, 1'b0};
        vecs[11] = '{12'hFFF, 32'h0000_0000, 1'b0, 32'h1234_5678, 32'h0000_0000, 1'b0};
        vecs[12] = '{12'h000, 32'h0000_0000, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0};
        vecs[13] = '{12'hFF0, 32'hFFFF_FE00, 1'b1, 32'h0000_0000, 32'h0000_01FF, 1'b0};
        vecs[14] = '{12'hFF0, 32'h0000_01FF, 1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

        reset = 1'b1;
        address_dmem = '0;
        d_dmem = '0;
        wren = 1'b0;
        ram_q = '0;
        btn_raw = '0;
        #12;
        check("reset_mole_led", 32'(mole_led), 32'h0);
        check("reset_score", 32'(score), 32'h0);
        rd(12'hFF3, v); check("reset_timer", v, 32'h0);
        reset = 1'b0;
        step(1);

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].addr, vecs[i].data, vecs[i].wr, vecs[i].rq);
            check($sformatf("vec%0d_q", i), q_dmem, vecs[i].exp_q);
            check($sformatf("vec%0d_ram_wren", i), 32'(ram_wren), 32'(vecs[i].exp_rw));
            if (vecs[i].wr) begin
                step(1);
                wren = 1'b0;
            end
        end
        check("mole_led_out", 32'(mole_led), 32'h1FF);
        check("score_out", 32'(score), 32'h42);

        // Timer: prescaler wraps every 3 edges after a load
        wr(12'hFF3, 32'h0);
        rd(12'hFF3, v); check("timer_load0", v, 32'h0);
        step(2);
        rd(12'hFF3, v); check("timer_before_wrap", v, 32'h0);
        step(1);
        rd(12'hFF3, v); check("timer_first_tick", v, 32'h1);
        wr(12'hFF3, 32'hFFFF_FFFF);
        step(3);
        rd(12'hFF3, v); check("timer_rollover", v, 32'h0);
        wr(12'hFF3, 32'h0);
        step(2);
        wr(12'hFF3, 32'h55);
        rd(12'hFF3, v); check("timer_write_in_wrap", v, 32'h55);
        step(2);
        rd(12'hFF3, v); check("timer_hold_after_write", v, 32'h55);
        step(1);
        rd(12'hFF3, v); check("timer_tick_after_write", v, 32'h56);

        // Debounce: level and event appear on the 6th edge
        btn_raw[3] = 1'b1;
        step(5);
        rd(12'hFF1, v); check("deb_level_edge5", v, 32'h0);
        rd(12'hFF2, v); check("deb_event_edge5", v, 32'h0);
        step(1);
        rd(12'hFF1, v); check("deb_level_edge6", v, 32'h008);
        rd(12'hFF2, v); check("deb_event_edge6", v, 32'h008);

        btn_raw[5] = 1'b1;
        step(3);
        btn_raw[5] = 1'b0;
        step(20);
        rd(12'hFF1, v); check("glitch_level", v, 32'h008);
        rd(12'hFF2, v); check("glitch_event", v, 32'h008);

        // W1C
        btn_raw[0] = 1'b1;
        step(6);
        rd(12'hFF2, v); check("events_009", v, 32'h009);
        wr(12'hFF2, 32'h001);
        rd(12'hFF2, v); check("w1c_bit0", v, 32'h008);
        btn_raw[0] = 1'b0;
        step(8);
        rd(12'hFF1, v); check("release_bit0", v, 32'h008);
        rd(12'hFF2, v); check("release_no_event", v, 32'h008);
        btn_raw[0] = 1'b1;
        step(5);
        wr(12'hFF2, 32'h009);
        rd(12'hFF2, v); check("set_beats_clear", v, 32'h001);
        rd(12'hFF1, v); check("level_after_rise", v, 32'h009);

        // Asynchronous reset between edges
        rd(12'hFF3, v);
        if (v === 32'h0) begin
            errors++;
            $display("FAIL timer_running: got 0x%08h expected nonzero", v);
        end
        checks++;
        step(1);
        reset = 1'b1;
        #1;
        check("async_mole_led", 32'(mole_led), 32'h0);
        check("async_score", 32'(score), 32'h0);
        rd(12'hFF3, v); check("async_timer", v, 32'h0);
        rd(12'hFF2, v); check("async_events", v, 32'h0);
        step(1);
        rd(12'hFF1, v); check("reset_levels", v, 32'h0);

`ifdef MMIO_RNG_EN
        rd(12'hFF5, v); check("rng_seed_in_reset", v, 32'h0000_ACE1);
        reset = 1'b0;
        rd(12'hFF5, v); check("rng_seed", v, 32'h0000_ACE1);
        step(1);
        rd(12'hFF5, v); check("rng_step1", v, 32'h0000_5670);
        zeros = 0;
        for (int i = 0; i < 1000; i++) begin
            step(1);
            rd(12'hFF5, v);
            if (v[15:0] == 16'h0 || v[31:16] != 16'h0) zeros++;
        end
        check("rng_nonzero_1000", 32'(zeros), 32'h0);
`else
        reset = 1'b0;
        rd(12'hFF5, v); check("rng_disabled0", v, 32'h0);
        step(7);
        rd(12'hFF5, v); check("rng_disabled1", v, 32'h0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
